// File: rtl/count_btn_ctrl.sv
// Push-button front end for the 15-bit up/down counter: synchronises the raw
// buttons and turns presses and held buttons into single-cycle up/dw/ld commands.
module count_btn_ctrl #(
  parameter int unsigned HOLD_TICKS = 4,
  parameter bit          SATURATE   = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_up,
  input  logic btn_dw,
  input  logic btn_ld,
  input  logic tick,
  input  logic utc,
  input  logic dtc,
  output logic up,
  output logic dw,
  output logic ld,
  output logic rpt
);

  // state   | meaning
  // IDLE    | no button held, waiting for a fresh press
  // UP_WAIT | up held, counting ticks before auto-repeat
  // UP_RPT  | up held long enough, one up pulse per tick
  // DW_WAIT | down held, counting ticks before auto-repeat
  // DW_RPT  | down held long enough, one dw pulse per tick
  // LOCK    | after load/conflict/reset, wait for all buttons released
  typedef enum logic [2:0] {
    IDLE,
    UP_WAIT,
    UP_RPT,
    DW_WAIT,
    DW_RPT,
    LOCK
  } state_t;

  localparam logic [7:0] HOLD8 = HOLD_TICKS[7:0];

  // bit 0 = up, bit 1 = dw, bit 2 = ld
  logic [2:0] s1_q, s1_d;
  logic [2:0] s2_q, s2_d;
  logic [2:0] prev_q, prev_d;
  logic [2:0] rise;

  state_t     state_q, state_d;
  logic [7:0] hold_q, hold_d;
  logic [7:0] hold_inc;
  logic       up_q, up_d;
  logic       dw_q, dw_d;
  logic       ld_q, ld_d;
  logic       rpt_q, rpt_d;
  logic       up_blk, dw_blk;

  always_comb begin
    s1_d   = {btn_ld, btn_dw, btn_up};
    s2_d   = s1_q;
    prev_d = s2_q;
    rise   = s2_q & ~prev_q;
  end

  assign up_blk   = SATURATE & utc;
  assign dw_blk   = SATURATE & dtc;
  assign hold_inc = hold_q + 8'd1;

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    up_d    = 1'b0;
    dw_d    = 1'b0;
    ld_d    = 1'b0;

    // A load press wins over anything else decided in the same cycle.
    if (rise[2] && (state_q != LOCK)) begin
      ld_d    = 1'b1;
      state_d = LOCK;
    end else begin
      unique case (state_q)
        LOCK: begin
          if (s2_q == 3'b000) state_d = IDLE;
        end
        IDLE: begin
          if (rise[0] && s2_q[1]) begin
            state_d = LOCK;
          end else if (rise[1] && s2_q[0]) begin
            state_d = LOCK;
          end else if (rise[0]) begin
            up_d    = ~up_blk;
            hold_d  = 8'd0;
            state_d = UP_WAIT;
          end else if (rise[1]) begin
            dw_d    = ~dw_blk;
            hold_d  = 8'd0;
            state_d = DW_WAIT;
          end
        end
        UP_WAIT: begin
          if (!s2_q[0]) begin
            state_d = IDLE;
          end else if (tick) begin
            if (hold_inc >= HOLD8) begin
              hold_d  = HOLD8;
              state_d = UP_RPT;
            end else begin
              hold_d = hold_inc;
            end
          end
        end
        UP_RPT: begin
          if (!s2_q[0]) state_d = IDLE;
          else if (tick) up_d = ~up_blk;
        end
        DW_WAIT: begin
          if (!s2_q[1]) begin
            state_d = IDLE;
          end else if (tick) begin
            if (hold_inc >= HOLD8) begin
              hold_d  = HOLD8;
              state_d = DW_RPT;
            end else begin
              hold_d = hold_inc;
            end
          end
        end
        DW_RPT: begin
          if (!s2_q[1]) state_d = IDLE;
          else if (tick) dw_d = ~dw_blk;
        end
        default: state_d = LOCK;
      endcase
    end

    rpt_d = (state_d == UP_RPT) || (state_d == DW_RPT);
  end

  // Sync chain resets high so a button held through reset never looks like a press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q    <= 3'b111;
      s2_q    <= 3'b111;
      prev_q  <= 3'b111;
      state_q <= LOCK;
      hold_q  <= 8'd0;
      up_q    <= 1'b0;
      dw_q    <= 1'b0;
      ld_q    <= 1'b0;
      rpt_q   <= 1'b0;
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      prev_q  <= prev_d;
      state_q <= state_d;
      hold_q  <= hold_d;
      up_q    <= up_d;
      dw_q    <= dw_d;
      ld_q    <= ld_d;
      rpt_q   <= rpt_d;
    end
  end

  assign up  = up_q;
  assign dw  = dw_q;
  assign ld  = ld_q;
  assign rpt = rpt_q;

endmodule

// File: tb/tb_count_btn_ctrl.sv
// Bench for count_btn_ctrl: a saturating and a wrapping instance share stimulus
// and are compared every cycle against a press/hold/lock reference model.
module tb_count_btn_ctrl;

  localparam int HOLD = 4;

  logic clk = 1'b0;
  logic rst_n, btn_up, btn_dw, btn_ld, tick, utc, dtc;
  logic s_up, s_dw, s_ld, s_rpt;
  logic w_up, w_dw, w_ld, w_rpt;

  always #5 clk = ~clk;

  count_btn_ctrl #(.HOLD_TICKS(HOLD), .SATURATE(1'b1)) u_sat (
    .clk(clk), .rst_n(rst_n), .btn_up(btn_up), .btn_dw(btn_dw), .btn_ld(btn_ld),
    .tick(tick), .utc(utc), .dtc(dtc), .up(s_up), .dw(s_dw), .ld(s_ld), .rpt(s_rpt));

  count_btn_ctrl #(.HOLD_TICKS(HOLD), .SATURATE(1'b0)) u_wrap (
    .clk(clk), .rst_n(rst_n), .btn_up(btn_up), .btn_dw(btn_dw), .btn_ld(btn_ld),
    .tick(tick), .utc(utc), .dtc(dtc), .up(w_up), .dw(w_dw), .ld(w_ld), .rpt(w_rpt));

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model. Index 0 = saturating instance, 1 = wrapping instance.
  // The synchroniser is a history of button samples: the decision at an edge
  // sees the level sampled two edges earlier, and a rise when the sample three
  // edges earlier was low.
  bit hu[3], hd[3], hl[3];
  int dirm[2];     // +1 up held, -1 down held, 0 none
  int nticks[2];   // ticks counted since the press
  bit locked[2];
  bit e_up[2], e_dw[2], e_ld[2], e_rpt[2];

  task automatic model_cfg(input int c, input bit sat_en, input bit lu, input bit ld_,
                           input bit ll, input bit ru, input bit rd, input bit rl);
    bit held;
    e_up[c] = 0; e_dw[c] = 0; e_ld[c] = 0;
    if (rl && !locked[c]) begin
      e_ld[c] = 1; locked[c] = 1; dirm[c] = 0;
    end else if (locked[c]) begin
      if (!lu && !ld_ && !ll) locked[c] = 0;
    end else if (dirm[c] == 0) begin
      if (ru && ld_) locked[c] = 1;
      else if (rd && lu) locked[c] = 1;
      else if (ru) begin dirm[c] = 1;  nticks[c] = 0; e_up[c] = !(sat_en && utc); end
      else if (rd) begin dirm[c] = -1; nticks[c] = 0; e_dw[c] = !(sat_en && dtc); end
    end else begin
      held = (dirm[c] > 0) ? lu : ld_;
      if (!held) dirm[c] = 0;
      else if (tick) begin
        if (nticks[c] >= HOLD) begin
          if (dirm[c] > 0) e_up[c] = !(sat_en && utc);
          else             e_dw[c] = !(sat_en && dtc);
        end else nticks[c]++;
      end
    end
    e_rpt[c] = (dirm[c] != 0) && (nticks[c] >= HOLD);
  endtask

  task automatic model_edge();
    bit lu, ld_, ll, ru, rd, rl;
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin hu[i] = 1; hd[i] = 1; hl[i] = 1; end
      for (int c = 0; c < 2; c++) begin
        dirm[c] = 0; nticks[c] = 0; locked[c] = 1;
        e_up[c] = 0; e_dw[c] = 0; e_ld[c] = 0; e_rpt[c] = 0;
      end
    end else begin
      lu = hu[1]; ld_ = hd[1]; ll = hl[1];
      ru = hu[1] & ~hu[2]; rd = hd[1] & ~hd[2]; rl = hl[1] & ~hl[2];
      model_cfg(0, 1'b1, lu, ld_, ll, ru, rd, rl);
      model_cfg(1, 1'b0, lu, ld_, ll, ru, rd, rl);
      hu[2] = hu[1]; hu[1] = hu[0]; hu[0] = btn_up;
      hd[2] = hd[1]; hd[1] = hd[0]; hd[0] = btn_dw;
      hl[2] = hl[1]; hl[1] = hl[0]; hl[0] = btn_ld;
    end
  endtask

  bit rnd = 0;
  int cnt_up, cnt_dw, cnt_ld, cnt_wup;
  bit seen_rpt;

  task automatic clr_cnt();
    cnt_up = 0; cnt_dw = 0; cnt_ld = 0; cnt_wup = 0; seen_rpt = 0;
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_edge();
      @(negedge clk);
      chk("sat_up",   s_up,  e_up[0]);
      chk("sat_dw",   s_dw,  e_dw[0]);
      chk("sat_ld",   s_ld,  e_ld[0]);
      chk("sat_rpt",  s_rpt, e_rpt[0]);
      chk("wrap_up",  w_up,  e_up[1]);
      chk("wrap_dw",  w_dw,  e_dw[1]);
      chk("wrap_ld",  w_ld,  e_ld[1]);
      chk("wrap_rpt", w_rpt, e_rpt[1]);
      cnt_up  += int'(s_up);
      cnt_dw  += int'(s_dw);
      cnt_ld  += int'(s_ld);
      cnt_wup += int'(w_up);
      if (s_rpt) seen_rpt = 1;
      tick = 1'b0;
      if (rnd) begin
        if ($urandom_range(0, 39) == 0) btn_up = ~btn_up;
        if ($urandom_range(0, 49) == 0) btn_dw = ~btn_dw;
        if ($urandom_range(0, 89) == 0) btn_ld = ~btn_ld;
        if ($urandom_range(0, 59) == 0) utc = ~utc;
        if ($urandom_range(0, 59) == 0) dtc = ~dtc;
        tick = ($urandom_range(0, 5) == 0);
      end
    end
  endtask

  task automatic ticks(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1;
      cyc(gap);
    end
  endtask

  initial begin
    rst_n = 0; btn_up = 1; btn_dw = 0; btn_ld = 0; tick = 0; utc = 0; dtc = 0;
    clr_cnt();
    cyc(3);
    rst_n = 1;
    cyc(10);
    chk("held_through_reset_up", cnt_up, 0);
    btn_up = 0;
    cyc(3);
    clr_cnt();
    btn_up = 1;
    cyc(2);
    chk("press_latency_early", cnt_up, 0);
    cyc(1);
    chk("press_latency_pulse", s_up, 1);
    cyc(3);
    chk("press_single_up", cnt_up, 1);
    btn_up = 0;
    cyc(5);

    // hold into auto-repeat: 1 initial pulse + one per tick from the 5th
    clr_cnt();
    btn_up = 1;
    cyc(4);
    ticks(4, 10);
    chk("rpt_after_4th_tick", s_rpt, 1);
    chk("no_pulse_before_rpt", cnt_up, 1);
    ticks(5, 10);
    chk("hold_up_count", cnt_up, 6);
    btn_up = 0;
    cyc(3);
    chk("rpt_drop_on_release", s_rpt, 0);
    cyc(5);

    // saturation on dtc
    clr_cnt();
    dtc = 1; btn_dw = 1;
    cyc(4);
    ticks(6, 10);
    chk("dtc_sat_dw_count", cnt_dw, 0);
    chk("dtc_sat_rpt_seen", seen_rpt, 1);
    dtc = 0;
    ticks(1, 10);
    chk("dtc_release_dw_count", cnt_dw, 1);
    btn_dw = 0;
    cyc(5);

    // simultaneous up/dw press locks
    clr_cnt();
    btn_up = 1; btn_dw = 1;
    cyc(4);
    ticks(6, 5);
    chk("conflict_up", cnt_up, 0);
    chk("conflict_dw", cnt_dw, 0);
    btn_up = 0; btn_dw = 0;
    cyc(4);
    btn_up = 1;
    cyc(5);
    chk("after_conflict_up", cnt_up, 1);
    btn_up = 0;
    cyc(5);

    // load during repeat
    btn_up = 1;
    cyc(4);
    ticks(5, 8);
    clr_cnt();
    btn_ld = 1;
    cyc(2);
    tick = 1;
    cyc(1);
    chk("ld_pulse", s_ld, 1);
    chk("ld_blocks_up", s_up, 0);
    ticks(4, 6);
    chk("ld_lock_up", cnt_up, 0);
    chk("ld_single", cnt_ld, 1);
    btn_ld = 0;
    ticks(3, 6);
    chk("ld_lock_up_still", cnt_up, 0);
    btn_up = 0;
    cyc(4);
    btn_up = 1;
    cyc(5);
    chk("ld_resume_up", cnt_up, 1);
    btn_up = 0;
    cyc(5);

    // wrapping instance ignores utc
    clr_cnt();
    utc = 1; btn_up = 1;
    cyc(5);
    chk("wrap_up_with_utc", cnt_wup, 1);
    chk("sat_up_with_utc", cnt_up, 0);
    btn_up = 0; utc = 0;
    cyc(5);

    // async reset mid-repeat
    btn_up = 1;
    cyc(4);
    ticks(5, 6);
    chk("pre_reset_rpt", s_rpt, 1);
    rst_n = 0;
    #1;
    chk("async_rst_rpt", s_rpt, 0);
    chk("async_rst_up", s_up, 0);
    cyc(3);
    rst_n = 1;
    clr_cnt();
    ticks(4, 5);
    chk("post_reset_lock_up", cnt_up, 0);
    btn_up = 0;
    cyc(4);
    btn_up = 1;
    cyc(5);
    chk("post_reset_press", cnt_up, 1);
    btn_up = 0;
    cyc(5);

    rnd = 1;
    cyc(6000);
    rnd = 0;
    btn_up = 0; btn_dw = 0; btn_ld = 0;
    cyc(10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/count_btn_ctrl.md
Name: count_btn_ctrl

Overview:
- Control stage directly upstream of the 15-bit loadable up/down counter.
- Turns raw push-button levels into the counter's single-cycle Up, Dw and LD command pulses.
- Features: 2-FF synchronisation, rising-edge detection, hold-to-auto-repeat paced by an external tick, and optional saturation at the counter's terminal counts using its UTC/DTC outputs.

Parameters:
- HOLD_TICKS, 4: number of tick pulses a button must stay held after its first pulse before auto-repeat starts (1..255).
- SATURATE, 1: 1 = suppress up pulses while utc=1 and dw pulses while dtc=1; 0 = no suppression (counter wraps).

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- btn_up  in  1  raw asynchronous up button level.
- btn_dw  in  1  raw asynchronous down button level.
- btn_ld  in  1  raw asynchronous load button level.
- tick  in  1  synchronous single-cycle pacing strobe (e.g. 4 Hz).
- utc  in  1  counter up terminal count (all ones).
- dtc  in  1  counter down terminal count (all zeros).
- up  out  1  one-cycle increment command to counter.
- dw  out  1  one-cycle decrement command to counter.
- ld  out  1  one-cycle load command to counter.
- rpt  out  1  high while in an auto-repeat state.

Behaviour:
- Reset (rst_n=0, async):
  - up=dw=ld=rpt=0; state=LOCK; hold counter=0.
  - Synchroniser and edge-history FFs all reset to 1, so a button held through reset never produces a pulse.
- Synchronisation: each button passes through FF s1 then s2; prev = s2 delayed one cycle; rise = s2 & ~prev.
- Outputs are registered and are never high for two consecutive cycles from the same event.
- Latency: button first sampled high at edge k -> rise valid after k+1 -> command pulse high for the one cycle following edge k+2.
- States: IDLE, UP_WAIT, UP_RPT, DW_WAIT, DW_RPT, LOCK.
- LOCK:
  - Exit to IDLE when synced up, dw and ld are all low; no pulses issued in LOCK.
- IDLE:
  - rise_up with synced dw low -> issue up (subject to saturation), clear hold counter, go UP_WAIT.
  - rise_dw with synced up low -> issue dw (subject to saturation), go DW_WAIT.
  - rise_up and rise_dw in the same cycle, or a rise while the other button is held -> no pulse, go LOCK.
- UP_WAIT:
  - Synced up low -> IDLE.
  - Each tick increments the hold counter.
  - On the tick that makes the count reach HOLD_TICKS -> go UP_RPT; no pulse on that tick.
  - dw activity ignored.
- UP_RPT:
  - Each tick -> up pulse in the following cycle (subject to saturation).
  - Synced up low -> IDLE.
  - rpt=1.
- DW_WAIT / DW_RPT: mirror of the UP states using btn_dw, dw and dtc.
- Load:
  - rise_ld in any state except LOCK -> ld pulse, go LOCK; overrides any same-cycle up/dw action.
  - Consequence: up/dw commands resume only after all buttons are released.
  - ld and up/dw are never high in the same cycle.
- Saturation (SATURATE=1):
  - up suppressed in any cycle where utc=1 at the decision edge; dw likewise with dtc.
  - FSM transitions still occur.
  - utc and dtc are sampled directly, not synchronised.
- tick coincident with release: release wins (go IDLE, no pulse).
- A tick while the FSM is in LOCK or IDLE is ignored.
- Hold counter: saturates at HOLD_TICKS; cleared on every entry to a *_WAIT state.
- Reset asserted mid-repeat: outputs drop to 0 immediately (async); after deassertion, LOCK until all buttons are released.

Test Plan:
- Reset, then hold btn_up high through rst_n release -> no up pulse; after btn_up low for 3 cycles and a fresh press at edge k, exactly one up pulse after edge k+2.
- HOLD_TICKS=4, tick every 10 cycles, btn_up held 100 cycles, utc=0:
  - 1 initial pulse; rpt rises on the 4th tick.
  - One up pulse per tick after that (5 more by the 9th tick).
  - rpt and pulses stop within 3 cycles of release.
- SATURATE=1, dtc=1, btn_dw pressed and held into repeat -> dw never asserted, rpt still asserts; drop dtc to 0 -> dw pulses resume on next tick.
- btn_up and btn_dw rise in the same cycle -> no up/dw pulse, FSM in LOCK until both are low; next single press works normally.
- During UP_RPT, press btn_ld -> one ld pulse, no up in that cycle; further ticks give no up until btn_up and btn_ld are both released and btn_up is pressed again.
- SATURATE=0, utc=1, btn_up pressed -> up pulse still issued (counter wraps to 0).
